// File: rtl/snn_cfg_sequencer.sv
// Configuration sequencer: turns SPI register-write strobes into shadow-register
// updates and commits them to the neuron parameter port over valid/ready.
module snn_cfg_sequencer #(
    parameter int         NREG       = 14,
    parameter logic [3:0] CMD_CLR    = 4'hE,
    parameter logic [3:0] CMD_COMMIT = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic [3:0] param_addr,
    output logic [7:0] param_data,
    output logic       param_valid,
    input  logic       param_ready,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] commit_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NREG - 1);

    state_t          state_r;
    logic            wr_en_q;
    logic [7:0]      shadow_r [NREG];
    logic [NREG-1:0] dirty_r;
    logic            pend_valid_r;
    logic [3:0]      pend_addr_r;
    logic [7:0]      pend_data_r;
    logic            full_r;
    logic [3:0]      idx_r;
    logic [3:0]      param_addr_r;
    logic [7:0]      param_data_r;
    logic            param_valid_r;
    logic            busy_r;
    logic            overflow_r;
    logic [7:0]      commit_count_r;

    logic            wr_pulse_s;
    logic            ev_valid_s;
    logic [3:0]      ev_addr_s;
    logic [7:0]      ev_data_s;
    logic            sel_s;

    // Rising-edge detect on wr_en and selection of the event to serve in IDLE.
    always_comb begin
        wr_pulse_s = wr_en & ~wr_en_q;
        sel_s      = full_r | dirty_r[idx_r];
        if (pend_valid_r) begin
            ev_valid_s = 1'b1;
            ev_addr_s  = pend_addr_r;
            ev_data_s  = pend_data_r;
        end else begin
            ev_valid_s = wr_pulse_s;
            ev_addr_s  = wr_addr;
            ev_data_s  = wr_data;
        end
    end

    // Sequencer state, shadow bank, pending slot and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            wr_en_q        <= 1'b0;
            for (int i = 0; i < NREG; i++) shadow_r[i] <= 8'h00;
            dirty_r        <= '0;
            pend_valid_r   <= 1'b0;
            pend_addr_r    <= 4'h0;
            pend_data_r    <= 8'h00;
            full_r         <= 1'b0;
            idx_r          <= 4'h0;
            param_addr_r   <= 4'h0;
            param_data_r   <= 8'h00;
            param_valid_r  <= 1'b0;
            busy_r         <= 1'b0;
            overflow_r     <= 1'b0;
            commit_count_r <= 8'h00;
        end else begin
            wr_en_q <= wr_en;
            // While a commit runs, writes park in the single slot or are dropped.
            if ((state_r != IDLE) && wr_pulse_s) begin
                if (!pend_valid_r) begin
                    pend_valid_r <= 1'b1;
                    pend_addr_r  <= wr_addr;
                    pend_data_r  <= wr_data;
                end else begin
                    overflow_r <= 1'b1;
                end
            end
            case (state_r)
                IDLE: begin
                    if (pend_valid_r) begin
                        if (wr_pulse_s) begin
                            pend_addr_r <= wr_addr;
                            pend_data_r <= wr_data;
                        end else begin
                            pend_valid_r <= 1'b0;
                        end
                    end
                    if (ev_valid_s) begin
                        if (ev_addr_s <= LAST_IDX) begin
                            shadow_r[ev_addr_s] <= ev_data_s;
                            dirty_r[ev_addr_s]  <= 1'b1;
                        end else if (ev_addr_s == CMD_CLR) begin
                            overflow_r <= 1'b0;
                        end else if (ev_addr_s == CMD_COMMIT) begin
                            full_r  <= ev_data_s[0];
                            idx_r   <= 4'h0;
                            state_r <= SCAN;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (sel_s) begin
                        param_addr_r  <= idx_r;
                        param_data_r  <= shadow_r[idx_r];
                        param_valid_r <= 1'b1;
                        state_r       <= SEND;
                    end else if (idx_r == LAST_IDX) begin
                        state_r <= DONE;
                    end else begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
                SEND: begin
                    if (param_ready) begin
                        param_valid_r  <= 1'b0;
                        dirty_r[idx_r] <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            state_r <= DONE;
                        end else begin
                            idx_r   <= idx_r + 4'd1;
                            state_r <= SCAN;
                        end
                    end
                end
                DONE: begin
                    commit_count_r <= commit_count_r + 8'd1;
                    state_r        <= IDLE;
                    busy_r         <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign param_addr   = param_addr_r;
    assign param_data   = param_data_r;
    assign param_valid  = param_valid_r;
    assign busy         = busy_r;
    assign overflow     = overflow_r;
    assign commit_count = commit_count_r;

endmodule

// File: tb/tb_snn_cfg_sequencer.sv
// Scoreboard bench for snn_cfg_sequencer: expected transfers and busy lengths are
// queued by the stimulus and consumed by independent monitors.
module tb_snn_cfg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic [3:0] param_addr;
    logic [7:0] param_data;
    logic       param_valid;
    logic       param_ready;
    logic       busy;
    logic       overflow;
    logic [7:0] commit_count;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [11:0] xfer_q [$];
    int          busy_q [$];

    snn_cfg_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .param_addr   (param_addr),
        .param_data   (param_data),
        .param_valid  (param_valid),
        .param_ready  (param_ready),
        .busy         (busy),
        .overflow     (overflow),
        .commit_count (commit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transfer monitor: a handshake seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n && param_valid && param_ready) begin
            if (xfer_q.size() == 0) begin
                check("unexpected_xfer", {20'h0, param_addr, param_data}, 32'hFFFF_FFFF);
            end else begin
                check("xfer", {20'h0, param_addr, param_data}, {20'h0, xfer_q.pop_front()});
            end
        end
    end

    // Backpressure monitor: a stalled transfer must hold valid, addr and data.
    logic       hold_prev = 1'b0;
    logic [3:0] prev_a;
    logic [7:0] prev_d;
    always @(negedge clk) begin
        if (rst_n && hold_prev)
            check("bp_stable", {19'h0, param_valid, param_addr, param_data}, {19'h0, 1'b1, prev_a, prev_d});
        hold_prev = rst_n && param_valid && !param_ready;
        prev_a    = param_addr;
        prev_d    = param_data;
    end

    // Busy monitor: measures each high period of busy in cycles.
    int run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else if (busy) begin
            run++;
        end else if (run > 0) begin
            if (busy_q.size() == 0) check("unexpected_busy", run, 32'hFFFF_FFFF);
            else check("busy_len", run, busy_q.pop_front());
            run = 0;
        end
    end

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int hold);
        @(posedge clk);
        #1;
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!param_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!param_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        wr_addr     = 4'h0;
        wr_data     = 8'h00;
        wr_en       = 1'b0;
        param_ready = 1'b1;
        #8;
        check("rst_valid", param_valid, 1'b0);
        check("rst_addr", param_addr, 4'h0);
        check("rst_data", param_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_cnt", commit_count, 8'h00);
        #4 rst_n = 1'b1;

        // Full commit right after reset: 14 zero transfers in order.
        for (int i = 0; i < 14; i++) xfer_q.push_back({4'(i), 8'h00});
        busy_q.push_back(29);
        do_write(4'hF, 8'h01, 1);
        wait_idle();
        check("cnt_full", commit_count, 8'd1);

        // Dirty-only commit of one register written with a long wr_en level.
        do_write(4'h3, 8'hA5, 10);
        xfer_q.push_back({4'h3, 8'hA5});
        busy_q.push_back(16);
        do_write(4'hF, 8'h00, 1);
        wait_idle();
        check("cnt_dirty1", commit_count, 8'd2);
        busy_q.push_back(15);
        do_write(4'hF, 8'h00, 1);
        wait_idle();
        check("cnt_dirty0", commit_count, 8'd3);

        // Backpressure: ready held low 5 cycles after valid rises.
        do_write(4'h5, 8'h3C, 1);
        param_ready = 1'b0;
        xfer_q.push_back({4'h5, 8'h3C});
        busy_q.push_back(21);
        do_write(4'hF, 8'h00, 1);
        wait_valid();
        check("bp_addr", param_addr, 4'h5);
        check("bp_data", param_data, 8'h3C);
        repeat (5) @(posedge clk);
        #1 param_ready = 1'b1;
        wait_idle();
        check("cnt_bp", commit_count, 8'd4);

        // Writes during a full commit: first is buffered, second is dropped.
        for (int i = 0; i < 14; i++)
            xfer_q.push_back({4'(i), (i == 3) ? 8'hA5 : (i == 5) ? 8'h3C : 8'h00});
        busy_q.push_back(29);
        do_write(4'hF, 8'h01, 1);
        do_write(4'h2, 8'h11, 1);
        do_write(4'h4, 8'h22, 1);
        wait_idle();
        check("ovf_set", overflow, 1'b1);
        check("cnt_busywr", commit_count, 8'd5);
        do_write(4'hE, 8'h00, 1);
        @(negedge clk);
        check("ovf_clr", overflow, 1'b0);
        xfer_q.push_back({4'h2, 8'h11});
        busy_q.push_back(16);
        do_write(4'hF, 8'h00, 1);
        wait_idle();
        check("cnt_pend", commit_count, 8'd6);

        // Reset while a transfer is stalled in SEND.
        do_write(4'h7, 8'h55, 1);
        param_ready = 1'b0;
        do_write(4'hF, 8'h00, 1);
        wait_valid();
        check("mid_addr", param_addr, 4'h7);
        check("mid_data", param_data, 8'h55);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", param_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_addr", param_addr, 4'h0);
        check("mid_rst_data", param_data, 8'h00);
        check("mid_rst_cnt", commit_count, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        param_ready = 1'b1;
        busy_q.push_back(15);
        do_write(4'hF, 8'h00, 1);
        wait_idle();
        check("cnt_after_rst", commit_count, 8'd1);

        // Counter wrap through 255 to 0.
        for (int i = 0; i < 254; i++) begin
            busy_q.push_back(15);
            do_write(4'hF, 8'h00, 1);
            wait_idle();
        end
        check("cnt_255", commit_count, 8'd255);
        busy_q.push_back(15);
        do_write(4'hF, 8'h00, 1);
        wait_idle();
        check("cnt_wrap", commit_count, 8'd0);

        repeat (3) @(negedge clk);
        check("xfer_q_empty", xfer_q.size(), 32'd0);
        check("busy_q_empty", busy_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
